// File: rtl/scan_pkg.sv
// Shared state encoding and sizing constants for the scan select generator.
package scan_pkg;

    localparam int SEL_W   = 2;
    localparam int NUM_OUT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2,
        STEP_DONE = 2'd3
    } scan_state_e;

endpackage

// File: rtl/scan_prescaler.sv
// Tick prescaler: counts 0..div_val and emits a registered one-cycle tick at terminal count.
module scan_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] lim_q, lim_d;
    logic             tick_q, tick_d;
    logic             act_q, act_d;

    // run is driven from the parent's next state, so the count register already
    // holds 0 in the first running cycle and tick lines up with count == limit.
    always_comb begin
        cnt_d  = '0;
        lim_d  = lim_q;
        tick_d = 1'b0;
        act_d  = 1'b0;
        if (run && !clr) begin
            act_d = 1'b1;
            if (!act_q || tick_q) begin
                cnt_d  = '0;
                lim_d  = div_val;
                tick_d = (div_val == '0);
            end else begin
                cnt_d  = cnt_q + DIV_W'(1);
                tick_d = ((cnt_q + DIV_W'(1)) == lim_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            lim_q  <= '0;
            tick_q <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lim_q  <= lim_d;
            tick_q <= tick_d;
            act_q  <= act_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/scan_sel_gen.sv
// Scan select generator: free-run or single-step walk over four decoder indices with skip mask.
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [DIV_W-1:0] div_val,
    input  logic [3:0]       skip_mask,
    input  logic             step_req,
    output logic             step_ack,
    output logic             a,
    output logic             b,
    output logic             tick,
    output logic             wrap
);

    scan_state_e      state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic             ack_q, ack_d;
    logic             advance;
    logic             tick_w;
    logic             presc_clr, presc_run;

    logic [SEL_W-1:0] cand_idx [NUM_OUT-1];
    logic [NUM_OUT-2:0] cand_free;
    logic [SEL_W-1:0] next_idx;
    logic             next_wrap;

    // Candidate gi is the index gi+1 positions above the current one (mod 4).
    for (genvar gi = 0; gi < NUM_OUT - 1; gi++) begin : g_cand
        assign cand_idx[gi]  = idx_q + SEL_W'(gi + 1);
        assign cand_free[gi] = ~skip_mask[cand_idx[gi]];
    end

    // Nearest free candidate wins; with none free the index holds and wraps unless all are skipped.
    always_comb begin
        next_idx  = idx_q;
        next_wrap = ~&skip_mask;
        for (int i = NUM_OUT - 2; i >= 0; i--) begin
            if (cand_free[i]) begin
                next_idx  = cand_idx[i];
                next_wrap = (cand_idx[i] < idx_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        ack_d   = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = mode ? STEP_WAIT : RUN;
                RUN: begin
                    advance = tick_w;
                    if (mode) state_d = STEP_WAIT;
                end
                STEP_WAIT: begin
                    if (!mode) begin
                        state_d = RUN;
                    end else if (step_req) begin
                        advance = 1'b1;
                        ack_d   = 1'b1;
                        state_d = STEP_DONE;
                    end
                end
                STEP_DONE: begin
                    if (!step_req) state_d = mode ? STEP_WAIT : RUN;
                end
                default:   state_d = IDLE;
            endcase
        end
        idx_d  = advance ? next_idx : idx_q;
        wrap_d = advance & next_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            ack_q   <= ack_d;
        end
    end

    assign presc_clr = ~en;
    assign presc_run = (state_d == RUN);

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (presc_clr),
        .run     (presc_run),
        .div_val (div_val),
        .tick    (tick_w)
    );

    assign a        = idx_q[1];
    assign b        = idx_q[0];
    assign tick     = tick_w;
    assign wrap     = wrap_q;
    assign step_ack = ack_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed self-checking bench for scan_sel_gen; outputs sampled on the falling clock edge.
module tb_scan_sel_gen;
    import scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] div_val = '0;
    logic [3:0] skip_mask = '0;
    logic       step_req = 1'b0;
    logic       step_ack, a, b, tick, wrap;

    int total = 0;
    int bad   = 0;
    int acks;

    scan_sel_gen #(.DIV_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .div_val   (div_val),
        .skip_mask (skip_mask),
        .step_req  (step_req),
        .step_ack  (step_ack),
        .a         (a),
        .b         (b),
        .tick      (tick),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ab", 32'({a, b}), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_ack", 32'(step_ack), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // free-run, div 3, no skips: tick every 4 cycles, 00,01,10,11,00, wrap on 11->00
        div_val = 8'd3; skip_mask = 4'b0000; mode = 1'b0; en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            chk("t1_tick", 32'(tick), 32'(n % 4 == 0));
            chk("t1_ab", 32'({a, b}), 32'(((n - 1) / 4) % 4));
            chk("t1_wrap", 32'(wrap), 32'(n == 17));
        end

        // div 0, skip 0101: alternate 01/11, wrap on every 11->01
        div_val = 8'd0; skip_mask = 4'b0101;
        for (int m = 1; m <= 8; m++) begin
            @(negedge clk);
            chk("t2_tick", 32'(tick), 32'd1);
            chk("t2_ab", 32'({a, b}), (m % 2 == 1) ? 32'd1 : 32'd3);
            chk("t2_wrap", 32'(wrap), 32'((m % 2 == 1) && (m >= 3)));
        end

        // land on index 2, then all-others-skipped holds with wrap, then 1111 holds without wrap
        skip_mask = 4'b1011;
        @(negedge clk);
        chk("t3_land_ab", 32'({a, b}), 32'd2);
        chk("t3_land_wrap", 32'(wrap), 32'd1);
        @(negedge clk);
        chk("t3_only_ab", 32'({a, b}), 32'd2);
        chk("t3_only_wrap", 32'(wrap), 32'd1);
        skip_mask = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("t3_all_ab", 32'({a, b}), 32'd2);
            chk("t3_all_wrap", 32'(wrap), 32'd0);
            chk("t3_all_tick", 32'(tick), 32'd1);
        end

        // advance to 3 mid-count, drop en, hold, re-enable: first tick after div_val+1 cycles
        skip_mask = 4'b0000; div_val = 8'd3;
        @(negedge clk);
        chk("t4_ab3", 32'({a, b}), 32'd3);
        chk("t4_tick0", 32'(tick), 32'd0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("t4_idle_state", 32'(dut.state_q), 32'(IDLE));
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_ab", 32'({a, b}), 32'd3);
            chk("t4_hold_tick", 32'(tick), 32'd0);
            @(negedge clk);
        end
        en = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            chk("t4_re_tick", 32'(tick), 32'(n == 4));
            chk("t4_re_ab", 32'({a, b}), 32'd3);
        end
        @(negedge clk);
        chk("t4_wrap_ab", 32'({a, b}), 32'd0);
        chk("t4_wrap", 32'(wrap), 32'd1);

        // single step: held request gives one advance and one ack
        mode = 1'b1;
        @(negedge clk);
        chk("t5_wait_state", 32'(dut.state_q), 32'(STEP_WAIT));
        chk("t5_wait_ab", 32'({a, b}), 32'd0);
        step_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acks += int'(step_ack);
            chk("t5_ack", 32'(step_ack), 32'(i == 0));
            chk("t5_ab", 32'({a, b}), 32'd1);
            chk("t5_tick", 32'(tick), 32'd0);
        end
        chk("t5_ack_count", 32'(acks), 32'd1);
        step_req = 1'b0;
        @(negedge clk);
        chk("t5_rel_state", 32'(dut.state_q), 32'(STEP_WAIT));
        chk("t5_rel_ack", 32'(step_ack), 32'd0);
        step_req = 1'b1;
        @(negedge clk);
        chk("t5_step2_ab", 32'({a, b}), 32'd2);
        chk("t5_step2_ack", 32'(step_ack), 32'd1);
        chk("t5_step2_state", 32'(dut.state_q), 32'(STEP_DONE));

        // asynchronous reset in STEP_DONE, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ab", 32'({a, b}), 32'd0);
        chk("t6_ack", 32'(step_ack), 32'd0);
        chk("t6_state", 32'(dut.state_q), 32'(IDLE));
        chk("t6_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_resume_state", 32'(dut.state_q), 32'(STEP_WAIT));
        chk("t6_resume_ab", 32'({a, b}), 32'd0);
        @(negedge clk);
        chk("t6_resume_step_ab", 32'({a, b}), 32'd1);
        chk("t6_resume_ack", 32'(step_ack), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, giving the prescaler width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: enables scanning.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = free-run, 1 = single-step.
REQ-006 The block SHALL have port div_val, input, DIV_W bits: tick period minus 1, in clk cycles.
REQ-007 The block SHALL have port skip_mask, input, 4 bits: bit i = 1 means index i is skipped.
REQ-008 The block SHALL have port step_req, input, 1 bit: single-step request, a level held until acknowledged.
REQ-009 The block SHALL have port step_ack, output, 1 bit: one-cycle acknowledge of a completed step.
REQ-010 The block SHALL have ports a and b, outputs, 1 bit each: registered 2-to-4 decoder select, {a,b} = index, a is MSB.
REQ-011 The block SHALL have port tick, output, 1 bit: one-cycle pulse at each prescaler terminal count.
REQ-012 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when the index advances to a value less than or equal to its previous value.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, STEP_WAIT and STEP_DONE.
REQ-014 In any state, en=0 SHALL force IDLE on the next edge, clear the prescaler, and hold the index.
REQ-015 IDLE SHALL go to RUN when en=1 and mode=0, and to STEP_WAIT when en=1 and mode=1.
REQ-016 A change of mode while en=1 SHALL take effect from RUN or STEP_WAIT on the next edge; a change during STEP_DONE SHALL take effect only after step_req falls.
REQ-017 In RUN, the prescaler SHALL count 0..div_val, pulse tick in the cycle where count == div_val, then reload 0.
REQ-018 div_val=0 SHALL produce tick every cycle.
REQ-019 div_val SHALL be sampled only at reload.
REQ-020 In RUN, each tick SHALL advance the index on that same edge, so the new {a,b} is visible one cycle after tick is high.
REQ-021 Advance SHALL select the next index (mod 4) above the current one whose skip_mask bit is 0.
REQ-022 If every other index is skipped, advance SHALL keep the current index, and wrap SHALL pulse.
REQ-023 If skip_mask=4'b1111, the index SHALL hold and wrap SHALL stay 0.
REQ-024 A skip bit set on the current index SHALL NOT move the index until the next advance.
REQ-025 In STEP_WAIT, step_req=1 SHALL advance the index once using the REQ-021..REQ-023 rules, pulse step_ack, and enter STEP_DONE.
REQ-026 STEP_DONE SHALL return to STEP_WAIT only after step_req=0 (4-phase handshake); a req still held SHALL NOT cause a further step.
REQ-027 The prescaler SHALL be idle and tick SHALL be 0 in STEP_WAIT and STEP_DONE.
REQ-028 tick, wrap and step_ack SHALL be registered one-cycle pulses and never asserted in IDLE.

Reset
REQ-029 rst_n=0 SHALL immediately set state=IDLE, index=0 (a=0, b=0), prescaler=0, and tick=wrap=step_ack=0.
REQ-030 Reset assertion mid-step or mid-count SHALL abandon the operation with no ack.
REQ-031 After rst_n rises, operation SHALL resume from the first rising clk edge.

Structure
REQ-032 Package scan_pkg SHALL hold the state enumeration and constants SEL_W=2 and NUM_OUT=4.
REQ-033 The prescaler SHALL be a sub-module scan_prescaler (ports clk, rst_n, clr, run, div_val, tick).
REQ-034 The FSM, the skip-advance logic and the output registers SHALL reside in scan_sel_gen.

Verification
REQ-035 Bench SHALL check: en=1, mode=0, div_val=3, skip_mask=0 -> tick every 4 cycles; {a,b} sequence 00,01,10,11,00; wrap with the 11->00 advance.
REQ-036 Bench SHALL check: div_val=0, skip_mask=4'b0101 -> {a,b} alternates 01,11, and wrap pulses on each 11->01.
REQ-037 Bench SHALL check: skip_mask=4'b1111 while at index 2 -> {a,b} stays 10 and wrap stays 0 for 20 ticks.
REQ-038 Bench SHALL check: mode=1, step_req held 10 cycles -> exactly one advance (00->01) and one step_ack pulse; after req drops and rises again -> 01->10.
REQ-039 Bench SHALL check: en dropped mid-count at index 3 -> {a,b} holds 11; re-enable -> first tick occurs div_val+1 cycles later.
REQ-040 Bench SHALL check: rst_n pulsed low asynchronously in STEP_DONE -> a=b=0 and step_ack=0 immediately, state IDLE.
